// File: rtl/z2_cycle_ctrl_pkg.sv
// rtl/z2_cycle_ctrl_pkg.sv - Zorro II bus-cycle state encoding shared with the function decoders
package z2_cycle_ctrl_pkg;

  // Function blocks decode these values directly, so the encoding is fixed.
  typedef enum logic [1:0] {
    Z2_IDLE  = 2'd0,
    Z2_START = 2'd1,
    Z2_DATA  = 2'd2,
    Z2_END   = 2'd3
  } z2_state_t;

  localparam int Z2_SYNC_STAGES_DEF = 2;
  localparam int Z2_TIMEOUT_DEF     = 255;

  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/z2_cycle_ctrl_strobe_sync.sv
// rtl/z2_cycle_ctrl_strobe_sync.sv - N-stage synchroniser for asynchronous bus strobes
module z2_cycle_ctrl_strobe_sync #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= RESET_VAL;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/z2_cycle_ctrl.sv
// rtl/z2_cycle_ctrl.sv - Zorro II slave bus-cycle sequencer with DTACK merge and timeout
module z2_cycle_ctrl
  import z2_cycle_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES    = Z2_SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYCLES = Z2_TIMEOUT_DEF
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       AS_n,
  input  logic       UDS_n,
  input  logic       LDS_n,
  input  logic       RW,
  input  logic       ADDR_MATCH,
  input  logic       SLAVE_DTACK,
  output logic [1:0] z2_state,
  output logic       DTACK,
  output logic       DBUF_OE_n,
  output logic       DBUF_DIR,
  output logic       TIMEOUT
);

  localparam int             CW        = cnt_width(TIMEOUT_CYCLES);
  localparam int             FW        = cnt_width(SYNC_STAGES);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(TIMEOUT_CYCLES);
  localparam logic [FW-1:0]  FILL_DONE = FW'(SYNC_STAGES);

  logic [1:0]    strobe_n_s;
  logic          as_gone;
  logic          ds_on;
  z2_state_t     state;
  logic [CW-1:0] cnt;
  logic [FW-1:0] fill;
  logic          armed;

  // Both strobes travel as active-low so the reset value of 1 reads as deasserted.
  z2_cycle_ctrl_strobe_sync #(
    .WIDTH    (2),
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(2'b11)
  ) u_strobe_sync (
    .clk    (CLK),
    .reset_n(RESET_n),
    .d      ({AS_n, UDS_n & LDS_n}),
    .q      (strobe_n_s)
  );

  assign as_gone  = strobe_n_s[1];
  assign ds_on    = !strobe_n_s[0];
  assign z2_state = state;

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state     <= Z2_IDLE;
      DTACK     <= 1'b0;
      DBUF_OE_n <= 1'b1;
      DBUF_DIR  <= 1'b0;
      TIMEOUT   <= 1'b0;
      cnt       <= '0;
      fill      <= '0;
      armed     <= 1'b0;
    end else begin
      TIMEOUT <= 1'b0;
      if (fill != FILL_DONE) fill <= fill + FW'(1);
      case (state)
        Z2_IDLE: begin
          DTACK     <= 1'b0;
          DBUF_OE_n <= 1'b1;
          DBUF_DIR  <= 1'b0;
          // A cycle may only start after AS has been genuinely seen high here;
          // sync flops still holding their reset value do not count.
          if (as_gone) begin
            armed <= (fill == FILL_DONE);
          end else begin
            armed <= 1'b0;
            if (armed && ADDR_MATCH) state <= Z2_START;
          end
        end
        Z2_START: begin
          if (as_gone) begin
            state     <= Z2_IDLE;
            DBUF_OE_n <= 1'b1;
            DBUF_DIR  <= 1'b0;
          end else begin
            DBUF_OE_n <= 1'b0;
            DBUF_DIR  <= RW;
            cnt       <= '0;
            if (ds_on) state <= Z2_DATA;
          end
        end
        Z2_DATA: begin
          if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
          if (as_gone) begin
            state     <= Z2_IDLE;
            DBUF_OE_n <= 1'b1;
            DBUF_DIR  <= 1'b0;
          end else if (SLAVE_DTACK) begin
            state <= Z2_END;
            DTACK <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state   <= Z2_END;
            DTACK   <= 1'b1;
            TIMEOUT <= 1'b1;
          end
        end
        Z2_END: begin
          if (as_gone) begin
            state     <= Z2_IDLE;
            DTACK     <= 1'b0;
            DBUF_OE_n <= 1'b1;
            DBUF_DIR  <= 1'b0;
          end else begin
            DTACK <= 1'b1;
          end
        end
        default: state <= Z2_IDLE;
      endcase
    end
  end

endmodule
